// File: rtl/sc_collatz_pkg.sv
// Shared constants and state encoding for the Collatz stepper.
// Imported by the stepper top and its arithmetic sub-block.
package sc_collatz_pkg;

    localparam int DATAWIDTH_DEF  = 8;
    localparam int COUNTWIDTH_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } stateT;

endpackage

// File: rtl/sc_collatz_nextval.sv
// Combinational Collatz successor: v/2 for even v, 3v+1 for odd v.
// The 3v+1 sum is formed two bits wider so overflow can be flagged.
module sc_collatz_nextval
    import sc_collatz_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic [DATAWIDTH-1:0] v,
    output logic [DATAWIDTH-1:0] next,
    output logic                 isOdd,
    output logic                 isOne,
    output logic                 isZero,
    output logic                 ovf
);

    logic [DATAWIDTH+1:0] triple;
    logic [DATAWIDTH+1:0] one;

    assign one    = {{(DATAWIDTH+1){1'b0}}, 1'b1};
    assign triple = {2'b00, v} + {1'b0, v, 1'b0} + one;

    assign isOdd  = v[0];
    assign isZero = (v == '0);
    assign isOne  = (v == {{(DATAWIDTH-1){1'b0}}, 1'b1});

    // Overflow only matters when the odd branch is actually taken.
    assign ovf  = isOdd & (|triple[DATAWIDTH+1:DATAWIDTH]);
    assign next = isOdd ? triple[DATAWIDTH-1:0] : (v >> 1);

endmodule

// File: rtl/sc_collatz_stepper.sv
// Collatz sequencer driving an external loadable register through its load port.
// Tracks step count and peak value; flags zero seed, overflow and counter saturation.
module sc_collatz_stepper
    import sc_collatz_pkg::*;
#(
    parameter int DATAWIDTH  = DATAWIDTH_DEF,
    parameter int COUNTWIDTH = COUNTWIDTH_DEF
) (
    input  logic                  SC_RegSHIFTER_CLOCK_50,
    input  logic                  SC_RegSHIFTER_RESET_InHigh,
    input  logic                  SC_STEPPER_start_InLow,
    input  logic [DATAWIDTH-1:0]  SC_STEPPER_seed_InBUS,
    input  logic [DATAWIDTH-1:0]  SC_STEPPER_reg_InBUS,
    output logic                  SC_STEPPER_load_OutLow,
    output logic [DATAWIDTH-1:0]  SC_STEPPER_next_OutBUS,
    output logic [COUNTWIDTH-1:0] SC_STEPPER_steps_OutBUS,
    output logic [DATAWIDTH-1:0]  SC_STEPPER_peak_OutBUS,
    output logic                  SC_STEPPER_busy_Out,
    output logic                  SC_STEPPER_done_Out,
    output logic                  SC_STEPPER_error_Out
);

    stateT                 stateQ;
    logic [DATAWIDTH-1:0]  seedQ;
    logic [COUNTWIDTH-1:0] stepsQ;
    logic [DATAWIDTH-1:0]  peakQ;
    logic                  doneQ;
    logic                  errorQ;

    logic [DATAWIDTH-1:0]  nextVal;
    logic                  isOdd;
    logic                  isOne;
    logic                  isZero;
    logic                  ovf;
    logic                  stepsFull;
    logic                  stepBad;
    logic                  stepOk;

    sc_collatz_nextval #(
        .DATAWIDTH(DATAWIDTH)
    ) uNextval (
        .v     (SC_STEPPER_reg_InBUS),
        .next  (nextVal),
        .isOdd (isOdd),
        .isOne (isOne),
        .isZero(isZero),
        .ovf   (ovf)
    );

    assign stepsFull = (stepsQ == {COUNTWIDTH{1'b1}});
    assign stepBad   = ~isZero & ~isOne & (ovf | stepsFull);
    assign stepOk    = ~isZero & ~isOne & ~ovf & ~stepsFull;

    always_comb begin
        SC_STEPPER_load_OutLow = 1'b1;
        SC_STEPPER_next_OutBUS = '0;
        if (stateQ == ST_LOAD) begin
            SC_STEPPER_load_OutLow = 1'b0;
            SC_STEPPER_next_OutBUS = seedQ;
        end else if (stateQ == ST_RUN && stepOk) begin
            SC_STEPPER_load_OutLow = 1'b0;
            SC_STEPPER_next_OutBUS = nextVal;
        end
    end

    always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
        if (SC_RegSHIFTER_RESET_InHigh) begin
            stateQ <= ST_IDLE;
            seedQ  <= '0;
            stepsQ <= '0;
            peakQ  <= '0;
            doneQ  <= 1'b0;
            errorQ <= 1'b0;
        end else begin
            unique case (stateQ)
                ST_LOAD: stateQ <= ST_RUN;
                ST_RUN: begin
                    // Conditions are disjoint and cover every value of v.
                    unique case (1'b1)
                        isZero: begin
                            stateQ <= ST_ERR;
                            errorQ <= 1'b1;
                        end
                        isOne: begin
                            stateQ <= ST_DONE;
                            doneQ  <= 1'b1;
                        end
                        stepBad: begin
                            stateQ <= ST_ERR;
                            errorQ <= 1'b1;
                        end
                        stepOk: begin
                            stepsQ <= stepsQ + 1'b1;
                            if (isOdd && nextVal > peakQ)
                                peakQ <= nextVal;
                        end
                    endcase
                end
                default: begin
                    if (!SC_STEPPER_start_InLow) begin
                        stateQ <= ST_LOAD;
                        seedQ  <= SC_STEPPER_seed_InBUS;
                        stepsQ <= '0;
                        peakQ  <= SC_STEPPER_seed_InBUS;
                        doneQ  <= 1'b0;
                        errorQ <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign SC_STEPPER_busy_Out     = (stateQ == ST_LOAD) || (stateQ == ST_RUN);
    assign SC_STEPPER_steps_OutBUS = stepsQ;
    assign SC_STEPPER_peak_OutBUS  = peakQ;
    assign SC_STEPPER_done_Out     = doneQ;
    assign SC_STEPPER_error_Out    = errorQ;

endmodule

// File: tb/tb_sc_collatz_stepper.sv
// Directed bench for sc_collatz_stepper with a behavioural loadable register
// closing the feedback loop, as in the real integration.
module tb_sc_collatz_stepper;

    logic       clk;
    logic       rst;
    logic       startN;
    logic [7:0] seed;
    logic [7:0] regQ;
    logic       loadN;
    logic [7:0] nextV;
    logic [7:0] steps;
    logic [7:0] peak;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int fails  = 0;

    sc_collatz_stepper dut (
        .SC_RegSHIFTER_CLOCK_50    (clk),
        .SC_RegSHIFTER_RESET_InHigh(rst),
        .SC_STEPPER_start_InLow    (startN),
        .SC_STEPPER_seed_InBUS     (seed),
        .SC_STEPPER_reg_InBUS      (regQ),
        .SC_STEPPER_load_OutLow    (loadN),
        .SC_STEPPER_next_OutBUS    (nextV),
        .SC_STEPPER_steps_OutBUS   (steps),
        .SC_STEPPER_peak_OutBUS    (peak),
        .SC_STEPPER_busy_Out       (busy),
        .SC_STEPPER_done_Out       (done),
        .SC_STEPPER_error_Out      (error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) regQ <= 8'd0;
        else if (!loadN) regQ <= nextV;
    end

    // Pulse start for one edge, then wait for done/error; cycles counts edges
    // from the accepting one, loads counts load pulses applied.
    task automatic runSeed(input logic [7:0] s, output int cycles,
                           output int loads, output bit timeout);
        seed   = s;
        startN = 1'b0;
        @(posedge clk);
        #1;
        startN = 1'b1;
        cycles = 1;
        loads  = 0;
        while (!(done || error) && cycles < 300) begin
            if (!loadN) loads++;
            @(posedge clk);
            #1;
            cycles++;
        end
        timeout = !(done || error);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        startN = 1'b1;
        seed = 8'd0;
        #5;
        checks++;
        if ({steps, peak, done, error, loadN, nextV, busy, regQ} !==
            {8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL reset: steps=%0d peak=%0d done=%b err=%b load=%b next=%0d busy=%b reg=%0d",
                     steps, peak, done, error, loadN, nextV, busy, regQ);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || loadN !== 1'b1) begin
            fails++;
            $display("FAIL idle_hold: busy=%b load=%b need 0/1", busy, loadN);
        end
    endtask

    task automatic test_seed6();
        int c, l;
        bit to;
        logic [7:0] exp [9] = '{8'd6, 8'd3, 8'd10, 8'd5, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1};
        int idx;
        seed = 8'd6;
        startN = 1'b0;
        @(posedge clk);
        #1;
        startN = 1'b1;
        c = 1;
        idx = 0;
        while (!(done || error) && c < 300) begin
            @(posedge clk);
            #1;
            c++;
            if (!(done || error) && idx < 9) begin
                checks++;
                if (regQ !== exp[idx]) begin
                    fails++;
                    $display("FAIL seq6[%0d]: reg=%0d need %0d", idx, regQ, exp[idx]);
                end
                idx++;
            end
        end
        checks++;
        if (c !== 11) begin
            fails++;
            $display("FAIL done_latency6: cycles=%0d need 11", c);
        end
        checks++;
        if ({done, error, steps, peak} !== {1'b1, 1'b0, 8'd8, 8'd16}) begin
            fails++;
            $display("FAIL result6: done=%b err=%b steps=%0d peak=%0d need 1/0/8/16",
                     done, error, steps, peak);
        end
        runSeed(8'd6, c, l, to);
        checks++;
        if (to || l !== 9) begin
            fails++;
            $display("FAIL loads6: loads=%0d timeout=%b need 9/0", l, to);
        end
    endtask

    task automatic test_seed1();
        int c, l;
        bit to;
        runSeed(8'd1, c, l, to);
        checks++;
        if (to || {done, error, steps, peak} !== {1'b1, 1'b0, 8'd0, 8'd1}) begin
            fails++;
            $display("FAIL result1: done=%b err=%b steps=%0d peak=%0d need 1/0/0/1",
                     done, error, steps, peak);
        end
        checks++;
        if (l !== 1 || c !== 3) begin
            fails++;
            $display("FAIL loads1: loads=%0d cycles=%0d need 1/3", l, c);
        end
    endtask

    task automatic test_seed0();
        int c, l;
        bit to;
        runSeed(8'd0, c, l, to);
        checks++;
        if (to || {error, done, steps, regQ} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            fails++;
            $display("FAIL result0: err=%b done=%b steps=%0d reg=%0d need 1/0/0/0",
                     error, done, steps, regQ);
        end
        checks++;
        if (c !== 3 || busy !== 1'b0) begin
            fails++;
            $display("FAIL timing0: cycles=%0d busy=%b need 3/0", c, busy);
        end
    endtask

    task automatic test_overflow();
        int c, l;
        bit to;
        runSeed(8'd27, c, l, to);
        checks++;
        if (to || {error, done, steps, peak, regQ} !==
            {1'b1, 1'b0, 8'd11, 8'd214, 8'd107}) begin
            fails++;
            $display("FAIL ovf27: err=%b done=%b steps=%0d peak=%0d reg=%0d need 1/0/11/214/107",
                     error, done, steps, peak, regQ);
        end
        checks++;
        if (c !== 14 || l !== 12) begin
            fails++;
            $display("FAIL ovf27_timing: cycles=%0d loads=%0d need 14/12", c, l);
        end
        @(posedge clk);
        #1;
        checks++;
        if (regQ !== 8'd107 || loadN !== 1'b1) begin
            fails++;
            $display("FAIL ovf27_hold: reg=%0d load=%b need 107/1", regQ, loadN);
        end
    endtask

    task automatic test_reset_midrun();
        int c, l;
        bit to;
        seed = 8'd7;
        startN = 1'b0;
        @(posedge clk);
        #1;
        startN = 1'b1;
        repeat (4) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        checks++;
        if ({steps, peak, done, error, loadN, nextV, busy, regQ} !==
            {8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL midrun_reset: steps=%0d peak=%0d done=%b err=%b load=%b next=%0d reg=%0d",
                     steps, peak, done, error, loadN, nextV, regQ);
        end
        @(negedge clk);
        rst = 1'b0;
        runSeed(8'd7, c, l, to);
        checks++;
        if (to || {done, error, steps, peak} !== {1'b1, 1'b0, 8'd16, 8'd52}) begin
            fails++;
            $display("FAIL result7: done=%b err=%b steps=%0d peak=%0d need 1/0/16/52",
                     done, error, steps, peak);
        end
    endtask

    task automatic test_start_ignored();
        int c, l;
        bit to;
        seed = 8'd6;
        startN = 1'b0;
        @(posedge clk);
        #1;
        startN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        seed = 8'd99;
        startN = 1'b0;
        @(posedge clk);
        #1;
        startN = 1'b1;
        c = 0;
        while (!(done || error) && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        checks++;
        if ({done, error, steps, peak} !== {1'b1, 1'b0, 8'd8, 8'd16}) begin
            fails++;
            $display("FAIL ignore_start: done=%b err=%b steps=%0d peak=%0d need 1/0/8/16",
                     done, error, steps, peak);
        end
        runSeed(8'd3, c, l, to);
        checks++;
        if (to || {done, steps, peak} !== {1'b1, 8'd7, 8'd16}) begin
            fails++;
            $display("FAIL fresh_run3: done=%b steps=%0d peak=%0d need 1/7/16",
                     done, steps, peak);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        seed = 8'd2;
        startN = 1'b0;
        c = 0;
        @(posedge clk);
        #1;
        while (!done && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || loadN !== 1'b0) begin
            fails++;
            $display("FAIL retrigger: busy=%b done=%b load=%b need 1/0/0", busy, done, loadN);
        end
        startN = 1'b1;
        c = 0;
        while (!done && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        checks++;
        if (done !== 1'b1 || steps !== 8'd1 || peak !== 8'd2) begin
            fails++;
            $display("FAIL retrigger_end: done=%b steps=%0d peak=%0d need 1/1/2", done, steps, peak);
        end
    endtask

    initial begin
        test_reset();
        test_seed6();
        test_seed1();
        test_seed0();
        test_overflow();
        test_reset_midrun();
        test_start_ignored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
